// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: state encoding and
// default frame/timebase parameters.
package uart_pkg;

  localparam int WORD_SIZE_DEF    = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  // Controller states. SEND covers start, data and stop bits alike; the
  // datapath bit counter (via bc_lt_bcmax) tells them apart.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timebase for the UART transmitter. Counts 0..CLKS_PER_BIT-1
// while running and flags the last cycle of each serial bit with o_tick.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_run,
  input  logic i_restart,
  output logic o_tick
);

  localparam int              CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running bit counter; restart wins so a new frame always starts aligned.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)          r_cnt <= '0;
    else if (i_restart)  r_cnt <= '0;
    else if (i_run)      r_cnt <= (r_cnt == LP_MAX) ? '0 : r_cnt + 1'b1;
  end

  // The counter only leaves zero while running, so no run gating is needed here.
  assign o_tick = (r_cnt == LP_MAX);

endmodule

// File: rtl/uart_tx_control.sv
// UART transmit sequencer. Accepts bytes over valid/ready and drives the
// datapath strobes that frame them as start + WORD_SIZE data + stop bits.
// Optional feature: define UART_TX_PREFETCH_EN to accept the next byte while
// a frame is still being sent, giving back-to-back frames with a single
// LOAD cycle between the stop bit and the next start bit.
module uart_tx_control
  import uart_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic tx_valid,
  output logic tx_ready,
  input  logic bc_lt_bcmax,
  output logic load_xmt_datareg,
  output logic load_xmt_shiftreg,
  output logic start,
  output logic shift,
  output logic clear,
  output logic busy
);

  if (CLKS_PER_BIT < 2 || WORD_SIZE < 1) begin : g_param_check
    $error("uart_tx_control: CLKS_PER_BIT must be >= 2 and WORD_SIZE >= 1");
  end

  tx_state_e r_state;
  logic      w_tick;
  logic      w_ready;
  logic      w_xfer;
  logic      w_stop_end;
  logic      w_next_frame;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst_b     (rst_b),
    .i_run     (r_state == ST_SEND),
    .i_restart (r_state == ST_LOAD),
    .o_tick    (w_tick)
  );

  assign w_xfer = tx_valid & w_ready;

  // Last cycle of the stop bit: bit counter has run past the data bits.
  assign w_stop_end = (r_state == ST_SEND) & w_tick & ~bc_lt_bcmax;

`ifdef UART_TX_PREFETCH_EN
  logic r_pending;

  assign w_ready = (r_state == ST_IDLE) | ((r_state == ST_SEND) & ~r_pending);

  // One-deep prefetch flag: the byte already sits in the data register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                  r_pending <= 1'b0;
    else if (r_state == ST_SEND) begin
      if (w_stop_end)            r_pending <= 1'b0;
      else if (w_xfer)           r_pending <= 1'b1;
    end
  end

  // A byte taken on the very cycle the stop bit ends also chains straight on.
  assign w_next_frame = r_pending | w_xfer;
`else
  assign w_ready      = (r_state == ST_IDLE);
  assign w_next_frame = 1'b0;
`endif

  // Frame sequencer: IDLE -> LOAD (one cycle) -> SEND until the stop bit ends.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_xfer) r_state <= ST_LOAD;
        ST_LOAD: r_state <= ST_SEND;
        ST_SEND: if (w_stop_end) r_state <= w_next_frame ? ST_LOAD : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decodes of registered state (plus the handshake/timebase),
  // so each lasts exactly one cycle.
  assign tx_ready          = w_ready;
  assign load_xmt_datareg  = w_xfer;
  assign load_xmt_shiftreg = (r_state == ST_LOAD);
  assign start             = (r_state == ST_LOAD);
  assign shift             = (r_state == ST_SEND) & w_tick & bc_lt_bcmax;
  assign clear             = (r_state == ST_LOAD) | w_stop_end;
  assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_control.sv
// Bench for uart_tx_control: two instances (4 and 2 clocks per bit), each
// with a small transmit datapath and a frame-level reference model.
module tb_uart_tx_control;

  localparam int W = 8;

`ifdef UART_TX_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int n_done      = 0;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int CPB  = (g == 0) ? 4 : 2;
    localparam int LAST = (W + 2) * CPB;
    localparam int G    = g;

    logic         rst_b, tv;
    logic [W-1:0] db;
    logic         ready, ld_dr, ld_sr, start, shift, clear, busy, bc_lt;
    logic [W-1:0] dreg;
    logic [W:0]   sreg;
    int           bcnt;
    logic         line;

    uart_tx_control #(.WORD_SIZE(W), .CLKS_PER_BIT(CPB)) dut (
      .clk               (clk),
      .rst_b             (rst_b),
      .tx_valid          (tv),
      .tx_ready          (ready),
      .bc_lt_bcmax       (bc_lt),
      .load_xmt_datareg  (ld_dr),
      .load_xmt_shiftreg (ld_sr),
      .start             (start),
      .shift             (shift),
      .clear             (clear),
      .busy              (busy)
    );

    // Transmit datapath: data register, shift register (line = bit 0), bit counter.
    always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        dreg <= '0;
        sreg <= '1;
        bcnt <= 0;
      end else begin
        if (ld_dr) dreg <= db;
        if (ld_sr)      sreg <= {dreg, !start};
        else if (shift) sreg <= {1'b1, sreg[W:1]};
        else if (start) sreg <= {sreg[W:1], 1'b0};
        if (clear)      bcnt <= 0;
        else if (shift) bcnt <= bcnt + 1;
      end
    end
    assign line  = sreg[0];
    assign bc_lt = (bcnt < W + 1);

    // Frame-level model: position k within the current frame (0 = LOAD cycle).
    bit           m_in, m_pend;
    int           m_k;
    logic [W-1:0] m_cur, m_nxt;
    bit           prev_busy;
    int           mon_busy, mon_sh, mon_clr;
    logic         line_hist [0:127];

    always @(negedge clk) begin
      logic [7:0] e, a;
      int         b;
      bit         e_rdy, xfer;
      logic       e_line;
      if (!rst_b) begin
        m_in   = 1'b0;
        m_pend = 1'b0;
        m_k    = 0;
      end
      e_rdy  = !m_in || (PF && m_k >= 1 && !m_pend);
      e_line = 1'b1;
      if (m_in && m_k >= 1) begin
        b = (m_k - 1) / CPB;
        if (b == 0)      e_line = 1'b0;
        else if (b <= W) e_line = m_cur[b-1];
        else             e_line = 1'b1;
      end
      e = {e_rdy, m_in, tv & e_rdy, m_in && m_k == 0, m_in && m_k == 0,
           m_in && m_k >= 1 && (m_k % CPB) == 0 && (m_k / CPB) <= W + 1,
           m_in && (m_k == 0 || m_k == LAST), e_line};
      a = {ready, busy, ld_dr, ld_sr, start, shift, clear, line};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cyc_cmp%0d t=%0d dut=%b model=%b (rdy,busy,ldd,lds,st,sh,clr,line)",
                 G, cyc, a, e);
      end
      check($sformatf("proto_shift%0d", G), int'(shift & !bc_lt), 0);
      check($sformatf("proto_ldd%0d", G), int'(ld_dr & !ready), 0);

      if (rst_b) begin
        xfer = tv && e_rdy;
        if (!m_in) begin
          if (xfer) begin m_in = 1'b1; m_k = 0; m_cur = db; end
        end else if (m_k == LAST) begin
          if (m_pend)    begin m_k = 0; m_cur = m_nxt; m_pend = 1'b0; end
          else if (xfer) begin m_k = 0; m_cur = db; end
          else           m_in = 1'b0;
        end else begin
          if (xfer) begin m_pend = 1'b1; m_nxt = db; end
          m_k++;
        end
      end

      if (busy && !prev_busy) begin
        mon_busy = 0;
        mon_sh   = 0;
        mon_clr  = 0;
      end
      if (busy) begin
        if (mon_busy < 128) line_hist[mon_busy] = line;
        mon_busy++;
        mon_sh  += int'(shift);
        mon_clr += int'(clear);
      end
      prev_busy = busy;
    end

    // Line value at the centre of each of the 10 bits of a frame whose LOAD
    // cycle sits at busy-cycle index base.
    function automatic int pat(input int base);
      logic [9:0] r;
      int         i;
      r = '0;
      for (int k = 0; k < 10; k++) begin
        i = base + 1 + k * CPB + CPB / 2;
        if (i < 128) r[k] = line_hist[i];
      end
      return int'(r);
    endfunction

    task automatic do_reset();
      rst_b = 1'b0; tv = 1'b0; db = '0;
      repeat (3) @(posedge clk);
      #1 rst_b = 1'b1;
      @(posedge clk); #1;
    endtask

    task automatic send(input logic [W-1:0] b, output int t_acc);
      tv = 1'b1; db = b; t_acc = -1;
      for (int n = 0; n < 400; n++) begin
        if (ready) begin t_acc = cyc; break; end
        @(posedge clk); #1;
      end
      if (t_acc < 0) fail($sformatf("send_timeout%0d", G));
      else begin @(posedge clk); #1; end
      tv = 1'b0;
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 2000) begin @(posedge clk); #1; n++; end
      if (busy) fail($sformatf("idle_timeout%0d", G));
    endtask

    task automatic random_bytes(input int cnt);
      int t;
      for (int i = 0; i < cnt; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send(W'($urandom), t);
        if ($urandom_range(0, 2) == 0) wait_idle();
      end
      wait_idle();
    endtask

    if (g == 0) begin : s4
      initial begin
        int t1, t2, n;
        do_reset();
        send(8'hA5, t1); wait_idle();
        check("a5_busy",  mon_busy, 41);
        check("a5_shift", mon_sh,   9);
        check("a5_clear", mon_clr,  2);
        check("a5_line",  pat(0),   10'b1101001010);

        repeat (3) @(posedge clk); #1;
        send(8'h12, t1); send(8'h34, t2);
        check("hold_accept_gap", t2 - t1, PF ? 2 : 42);
        wait_idle();

        send(8'h00, t1); send(8'hFF, t2); wait_idle();
        check("ff_busy", mon_busy, PF ? 82 : 41);
        check("ff_line", pat(PF ? 41 : 0), 10'b1111111110);

        repeat (2) @(posedge clk); #1;
        send(8'h3C, t1);
        n = 0;
        while (mon_sh < 3 && n < 200) begin @(posedge clk); #1; n++; end
        if (mon_sh < 3) fail("wait_3rd_shift");
        rst_b = 1'b0;
        #1;
        check("rst_mid_outputs",
              int'({busy, ready, line, ld_dr, ld_sr, start, shift, clear}), 8'b0110_0000);
        @(posedge clk); @(posedge clk); #1 rst_b = 1'b1;
        @(posedge clk); #1;
        send(8'h81, t1); wait_idle();
        check("x81_busy",  mon_busy, 41);
        check("x81_shift", mon_sh,   9);
        check("x81_line",  pat(0),   10'b1100000010);

        random_bytes(25);
        n_done++;
      end
    end else begin : s2
      initial begin
        int t1;
        do_reset();
        send(8'h55, t1); wait_idle();
        check("cpb2_busy",  mon_busy, 21);
        check("cpb2_shift", mon_sh,   9);
        check("cpb2_clear", mon_clr,  2);
        check("cpb2_line",  pat(0),   10'b1010101010);
        random_bytes(10);
        n_done++;
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (n_done < 2 && n < 20000) begin @(posedge clk); n++; end
    if (n_done < 2) fail("global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
